// File: rtl/stepper_pkg.sv
// Shared encodings and default sizing for the stepper command sequencer.
package stepper_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PER_W      = 24;
    localparam int DEF_MIN_PERIOD = 2;
    localparam int DEF_DIR_SETUP  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } seq_state_t;

endpackage

// File: rtl/step_timer.sv
// Step period counter: counts 0..P-1 and strobes tc on P-1, with P clamped to MIN_PERIOD.
module step_timer #(
    parameter int PER_W      = 24,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PER_W-1:0] period,
    input  logic             clear,
    input  logic             en,
    output logic             tc
);

    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] cnt;

    function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
        if (p < PER_W'(MIN_PERIOD)) begin
            return PER_W'(MIN_PERIOD);
        end
        return p;
    endfunction

    assign tc = en && (cnt == per_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_q <= PER_W'(MIN_PERIOD);
            cnt   <= '0;
        end else begin
            if (load) begin
                per_q <= clamp_period(period);
            end
            if (clear || load) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= tc ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Command-driven step sequencer: one pending slot, direction settle, timed step ticks.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PER_W      = DEF_PER_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int DIR_SETUP  = DEF_DIR_SETUP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_steps,
    input  logic [PER_W-1:0]        cmd_period,
    input  logic                    abort,
    output logic                    step_tick,
    output logic                    motor_dir,
    output logic                    motor_en,
    output logic                    busy,
    output logic                    done,
    output logic signed [CNT_W-1:0] position
);

    localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic signed [CNT_W-1:0] POS_ONE = 1;

    seq_state_t       state, next_state;
    logic             pend_full;
    logic             pend_dir;
    logic [CNT_W-1:0] pend_steps;
    logic [PER_W-1:0] pend_period;
    logic [CNT_W-1:0] rem;
    logic [SET_W-1:0] settle_cnt;
    logic             accept;
    logic             timer_en;
    logic             timer_clear;
    logic             tc;

    assign cmd_ready   = !pend_full && !abort;
    assign accept      = cmd_valid && cmd_ready;
    assign timer_en    = (state == ST_RUN) && (rem != '0) && !abort;
    assign timer_clear = (state != ST_RUN) || abort;
    assign step_tick   = tc;
    assign done        = (state == ST_RUN) && (rem == '0) && !abort;
    assign motor_en    = (state != ST_IDLE);
    assign busy        = (state != ST_IDLE) || pend_full;

    step_timer #(
        .PER_W      (PER_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_LOAD),
        .period (pend_period),
        .clear  (timer_clear),
        .en     (timer_en),
        .tc     (tc)
    );

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (pend_full) next_state = ST_LOAD;
                ST_LOAD: begin
                    // A zero-step move reports done without touching the direction line.
                    if (pend_steps == '0)          next_state = ST_RUN;
                    else if (pend_dir != motor_dir) next_state = ST_SETTLE;
                    else                           next_state = ST_RUN;
                end
                ST_SETTLE: if (settle_cnt == SET_W'(DIR_SETUP - 1)) next_state = ST_RUN;
                ST_RUN:    if (rem == '0) next_state = pend_full ? ST_LOAD : ST_IDLE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_full  <= 1'b0;
            rem        <= '0;
            settle_cnt <= '0;
            motor_dir  <= 1'b0;
            position   <= '0;
        end else begin
            state      <= next_state;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (abort)                   pend_full <= 1'b0;
            else if (accept)             pend_full <= 1'b1;
            else if (state == ST_LOAD)   pend_full <= 1'b0;
            if (abort)                   rem <= '0;
            else if (state == ST_LOAD)   rem <= pend_steps;
            else if (tc)                 rem <= rem - 1'b1;
            if (!abort && (state == ST_LOAD) && (pend_steps != '0)) begin
                motor_dir <= pend_dir;
            end
            if (tc) begin
                position <= motor_dir ? position + POS_ONE : position - POS_ONE;
            end
        end
    end

    // Pending command payload is only consumed while pend_full is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_dir    <= cmd_dir;
            pend_steps  <= cmd_steps;
            pend_period <= cmd_period;
        end
    end

endmodule
